mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, combinational-read word memory between the instruction-fetch port and the data port of the multi-cycle core.
- Each port uses a req/ready request handshake and an rvalid response.
- The block owns the memory's we/addr/wdata and inserts a programmable number of wait states per access.
- Data has priority, with a starvation guard for fetch.

Parameters:
- WAIT_CYCLES, 1, extra cycles the address is held before read capture or write commit (0 allowed).
- STARVE_LIMIT, 3, consecutive data grants while fetch waits before fetch is forced to win (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_ready  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid (1 cycle).
- if_rdata  out  32  fetch read data.
- dm_req  in  1  data request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  write data.
- dm_ready  out  1  data request accepted this cycle.
- dm_rvalid  out  1  data response / write ack (1 cycle).
- dm_rdata  out  32  data read data (0 on write ack).
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address (memory indexes addr[31:2]).
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async):
  - State goes to IDLE; counters clear.
  - All outputs read 0 immediately: ready, rvalid, rdata, mem_we, mem_addr, mem_wdata.
  - An in-flight access is dropped. A write is not committed if reset is asserted before its commit edge.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, grant one port and assert that port's ready combinationally in the same cycle.
  - Latch owner, addr, we (fetch always read), and wdata.
  - Load wait counter with WAIT_CYCLES; go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS:
  - mem_addr = latched addr; mem_wdata = latched wdata for writes, else 0.
  - While counter > 0, decrement.
  - When counter == 0, this is the final cycle:
    - Write: mem_we = 1 for exactly this cycle; commit occurs on the ending edge.
    - Read: mem_rdata is captured into the response register on the ending edge.
  - Go to RESP.
- RESP:
  - Owner's rvalid = 1 for exactly one cycle.
  - Owner's rdata = captured word (0 for a write ack). The non-owner's rdata is 0.
  - mem_addr = 0, mem_we = 0. Go to IDLE.
- Requests are not accepted in ACCESS or RESP; ready is 0 there.
- Latency: acceptance cycle, then WAIT_CYCLES+1 ACCESS cycles, then RESP.
  - rvalid appears WAIT_CYCLES+2 cycles after the ready cycle.
  - Minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Arbitration when both reqs are high in IDLE:
  - Data wins unless starve_cnt == STARVE_LIMIT; then fetch wins.
  - starve_cnt increments on each data grant while if_req is high.
  - starve_cnt clears on any fetch grant. It saturates at STARVE_LIMIT.
  - A single requester is always granted immediately.
- Requester protocol:
  - Hold req/addr/we/wdata stable until ready is seen.
  - Deasserting req before ready is illegal; the bench flags it as an assertion.
  - req may stay high after ready; it then counts as a new request at the next IDLE.
- Addresses pass through unmodified, including the low 2 bits. Out-of-range addresses are the memory's concern.
- Counter width is max(1, clog2(WAIT_CYCLES+1)).

Decomposition:
- Shared package mem_arb_pkg:
  - State enum arb_state_t {IDLE, ACCESS, RESP}.
  - Owner enum arb_owner_t {OWN_IF, OWN_DM}.
- u1/u32 come from the common types header.
- Sub-module mem_arb_prio:
  - Inputs: if_req, dm_req, an enable (state==IDLE), clk, reset.
  - Outputs: one-hot grant.
  - Holds the starvation counter.

Test Plan:
- Single data read:
  - Stimulus: WAIT_CYCLES=1, mem[5]=0xDEADBEEF, dm_req with addr 0x14, we=0.
  - Response: dm_ready in cycle 0; mem_addr=0x14 in cycles 1–2; dm_rvalid in cycle 3 with dm_rdata=0xDEADBEEF; if_rvalid stays 0.
- Data write:
  - Stimulus: addr 0x8, wdata 0x12345678.
  - Response: mem_we high exactly 1 cycle (the last ACCESS cycle); dm_rvalid with dm_rdata=0; a follow-up read of 0x8 returns 0x12345678.
- Contention / starvation:
  - Stimulus: STARVE_LIMIT=3, if_req and dm_req held high continuously.
  - Response: grant order DM, DM, DM, IF, DM, DM, DM, IF…; if_addr=0x40 returns mem[16].
- WAIT_CYCLES=0:
  - Response: ACCESS lasts 1 cycle; rvalid 2 cycles after ready; back-to-back requests are accepted every 3 cycles.
- Reset mid-write:
  - Stimulus: assert reset during the first ACCESS cycle of a write to 0xC with WAIT_CYCLES=2.
  - Response: mem_we never pulses; mem[3] is unchanged; all outputs drop to 0 asynchronously; the next request after release completes normally.
- Idle / no request:
  - Response: no req for 10 cycles keeps all outputs 0; req arriving the same cycle reset releases is accepted on the first clock with reset low.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic       {OWN_IF, OWN_DM}     arb_owner_t;

  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_DM = 1;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed data-first priority with a starvation guard that lets fetch win
// after STARVE_LIMIT consecutive data grants made while fetch was waiting.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_if_req,
  input  logic       i_dm_req,
  output logic [1:0] o_grant
);

  localparam int unsigned SW = cnt_width(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;
  logic          w_force_if;

  assign w_force_if = (r_starve == SW'(STARVE_LIMIT));

  always_comb begin
    o_grant = '0;
    if (i_en) begin
      if (i_if_req && (!i_dm_req || w_force_if)) begin
        o_grant[GNT_IF] = 1'b1;
      end else if (i_dm_req) begin
        o_grant[GNT_DM] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (o_grant[GNT_IF]) begin
      r_starve <= '0;
    end else if (o_grant[GNT_DM] && i_if_req && !w_force_if) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational-read memory between fetch and data ports,
// inserting WAIT_CYCLES wait states per access before capture/commit.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = cnt_width(WAIT_CYCLES + 1);

  arb_state_t    r_state;
  arb_owner_t    r_owner;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [CW-1:0] r_cnt;

  logic          w_en;
  logic [1:0]    w_grant;
  logic          w_last;
  logic          w_resp;

  // Gating with reset keeps ready low while reset is held, even with req high.
  assign w_en = (r_state == IDLE) && !reset;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_en     (w_en),
    .i_if_req (if_req),
    .i_dm_req (dm_req),
    .o_grant  (w_grant)
  );

  assign if_ready = w_grant[GNT_IF];
  assign dm_ready = w_grant[GNT_DM];
  assign w_last   = (r_state == ACCESS) && (r_cnt == '0);
  assign w_resp   = (r_state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_owner <= w_grant[GNT_DM] ? OWN_DM : OWN_IF;
            r_addr  <= w_grant[GNT_DM] ? dm_addr : if_addr;
            r_we    <= w_grant[GNT_DM] && dm_we;
            r_wdata <= (w_grant[GNT_DM] && dm_we) ? dm_wdata : '0;
            r_cnt   <= CW'(WAIT_CYCLES);
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rdata <= r_we ? '0 : mem_rdata;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = (r_state == ACCESS) ? r_addr : '0;
  assign mem_wdata = (r_state == ACCESS) ? r_wdata : '0;
  assign mem_we    = w_last && r_we;

  assign if_rvalid = w_resp && (r_owner == OWN_IF);
  assign dm_rvalid = w_resp && (r_owner == OWN_DM);
  assign if_rdata  = if_rvalid ? r_rdata : '0;
  assign dm_rdata  = dm_rvalid ? r_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (WAIT_CYCLES 1, 0, 2),
// each with its own word memory model.
module tb_mem_arbiter;

  typedef struct {
    bit          dm;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst = '1;
  logic [2:0]  if_req = '0;
  logic [2:0]  dm_req = '0;
  logic [2:0]  dm_we = '0;
  logic [31:0] if_addr  [3];
  logic [31:0] dm_addr  [3];
  logic [31:0] dm_wdata [3];

  logic [2:0]  if_ready, if_rvalid, dm_ready, dm_rvalid, mem_we;
  logic [31:0] if_rdata  [3];
  logic [31:0] dm_rdata  [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];

  logic [31:0] mem [3][64];
  logic        pl_we = 1'b0;
  logic [5:0]  pl_addr = '0;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int g, input int i);
    if (g == 0 && i == 5) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(g * 65536 + i);
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (pl_we) mem[g][pl_addr] <= pat(g, int'(pl_addr));
      else if (mem_we[g]) mem[g][mem_addr[g][7:2]] <= mem_wdata[g];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 0 : 2);

    mem_arbiter #(
      .WAIT_CYCLES (WC),
      .STARVE_LIMIT(3)
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_ready (if_ready[g]),
      .if_rvalid(if_rvalid[g]),
      .if_rdata (if_rdata[g]),
      .dm_req   (dm_req[g]),
      .dm_we    (dm_we[g]),
      .dm_addr  (dm_addr[g]),
      .dm_wdata (dm_wdata[g]),
      .dm_ready (dm_ready[g]),
      .dm_rvalid(dm_rvalid[g]),
      .dm_rdata (dm_rdata[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );

    assign mem_rdata[g] = mem[g][mem_addr[g][7:2]];

    a_if_hold: assert property (@(posedge clk) disable iff (rst[g])
      (if_req[g] && !if_ready[g]) |=> if_req[g])
      else $error("FAIL if_req_dropped_before_ready inst %0d", g);
    a_dm_hold: assert property (@(posedge clk) disable iff (rst[g])
      (dm_req[g] && !dm_ready[g]) |=> dm_req[g])
      else $error("FAIL dm_req_dropped_before_ready inst %0d", g);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int k, input bit to_dm, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int waited);
    if (to_dm) begin
      dm_req[k] = 1'b1; dm_we[k] = we; dm_addr[k] = addr; dm_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    waited = 0;
    #1;
    while (!(to_dm ? dm_ready[k] : if_ready[k]) && waited < 20) begin
      tick();
      waited++;
    end
  endtask

  task automatic wait_rsp(input int k, input bit drop_if, input bit drop_dm,
                          output bit got, output bit own_dm, output logic [31:0] data,
                          output int lat, output int we_cnt, output int we_at);
    got = 0; own_dm = 0; data = '0; lat = 0; we_cnt = 0; we_at = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (c == 1) begin
        if (drop_if) if_req[k] = 1'b0;
        if (drop_dm) dm_req[k] = 1'b0;
        #1;
      end
      if (mem_we[k]) begin we_cnt++; we_at = c; end
      if (if_rvalid[k] || dm_rvalid[k]) begin
        got = 1; own_dm = dm_rvalid[k];
        data = dm_rvalid[k] ? dm_rdata[k] : if_rdata[k];
        lat = c;
      end
    end
  endtask

  task automatic test_reset();
    if_req[0] = 1'b1; dm_req[0] = 1'b1;
    #2;
    checks++;
    if ({if_ready[0], dm_ready[0]} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b exp=00", {if_ready[0], dm_ready[0]});
    end
    checks++;
    if ({if_rvalid[0], dm_rvalid[0], mem_we[0]} !== 3'b000 || if_rdata[0] !== '0 || dm_rdata[0] !== '0) begin
      errors++; $display("FAIL reset_resp got=%b/%h/%h exp=0", {if_rvalid[0], dm_rvalid[0], mem_we[0]}, if_rdata[0], dm_rdata[0]);
    end
    checks++;
    if (mem_addr[0] !== '0 || mem_wdata[0] !== '0) begin
      errors++; $display("FAIL reset_membus got=%h/%h exp=0", mem_addr[0], mem_wdata[0]);
    end
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      pl_we = 1'b1; pl_addr = 6'(i);
    end
    tick();
    pl_we = 1'b0;
    rst = '0;
    tick();
  endtask

  task automatic test_single_read();
    int w; rsp_t e;
    issue(0, 1, 0, 32'h14, '0, w);
    checks++;
    if (w !== 0 || if_ready[0] !== 1'b0) begin
      errors++; $display("FAIL rd_ready got=wait%0d/if%b exp=wait0/if0", w, if_ready[0]);
    end
    exp_q.push_back('{dm: 1'b1, data: pat(0, 5)});
    tick();
    dm_req[0] = 1'b0;
    #1;
    checks++;
    if (mem_addr[0] !== 32'h14) begin
      errors++; $display("FAIL rd_addr_c1 got=%h exp=00000014", mem_addr[0]);
    end
    tick();
    checks++;
    if (mem_addr[0] !== 32'h14 || dm_rvalid[0] !== 1'b0) begin
      errors++; $display("FAIL rd_addr_c2 got=%h/%b exp=00000014/0", mem_addr[0], dm_rvalid[0]);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (dm_rvalid[0] !== e.dm || if_rvalid[0] !== 1'b0 || dm_rdata[0] !== e.data || if_rdata[0] !== '0) begin
      errors++; $display("FAIL rd_resp got=v%b/%b d=%h if_d=%h exp=v1/0 d=%h if_d=0",
                         dm_rvalid[0], if_rvalid[0], dm_rdata[0], if_rdata[0], e.data);
    end
    tick();
    checks++;
    if (mem_addr[0] !== '0 || dm_rvalid[0] !== 1'b0) begin
      errors++; $display("FAIL rd_back_idle got=%h/%b exp=0/0", mem_addr[0], dm_rvalid[0]);
    end
  endtask

  task automatic test_write();
    int w, lat, wc, wa; bit got, own; logic [31:0] d; rsp_t e;
    issue(0, 1, 1, 32'h8, 32'h12345678, w);
    exp_q.push_back('{dm: 1'b1, data: 32'h0});
    wait_rsp(0, 0, 1, got, own, d, lat, wc, wa);
    e = exp_q.pop_front();
    checks++;
    if (!got || own !== e.dm || d !== e.data || lat != 3) begin
      errors++; $display("FAIL wr_ack got=%b own=%b d=%h lat=%0d exp=1/1/%h/3", got, own, d, lat, e.data);
    end
    checks++;
    if (wc != 1 || wa != 2) begin
      errors++; $display("FAIL wr_we_pulse got=cnt%0d at%0d exp=cnt1 at2", wc, wa);
    end
    checks++;
    if (mem[0][2] !== 32'h12345678) begin
      errors++; $display("FAIL wr_mem got=%h exp=12345678", mem[0][2]);
    end
    tick();
    issue(0, 1, 0, 32'h8, '0, w);
    exp_q.push_back('{dm: 1'b1, data: 32'h12345678});
    wait_rsp(0, 0, 1, got, own, d, lat, wc, wa);
    e = exp_q.pop_front();
    checks++;
    if (!got || own !== e.dm || d !== e.data || wc != 0) begin
      errors++; $display("FAIL wr_readback got=%b/%b d=%h we=%0d exp=1/1/%h/0", got, own, d, wc, e.data);
    end
    tick();
  endtask

  task automatic test_contention();
    int lat, wc, wa; bit got, own, exp_dm; logic [31:0] d; rsp_t e;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h20;
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    #1;
    for (int i = 0; i < 9; i++) begin
      exp_dm = (i % 4) != 3;
      checks++;
      if ({dm_ready[0], if_ready[0]} !== (exp_dm ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL arb_grant%0d got=%b exp=%b", i, {dm_ready[0], if_ready[0]}, exp_dm ? 2'b10 : 2'b01);
      end
      exp_q.push_back('{dm: exp_dm, data: exp_dm ? pat(0, 8) : pat(0, 16)});
      wait_rsp(0, i == 7, i == 8, got, own, d, lat, wc, wa);
      e = exp_q.pop_front();
      checks++;
      if (!got || own !== e.dm || d !== e.data) begin
        errors++; $display("FAIL arb_resp%0d got=%b own=%b d=%h exp=1 own=%b d=%h", i, got, own, d, e.dm, e.data);
      end
      tick();
    end
  endtask

  task automatic test_wait0();
    int lat, wc, wa; bit got, own; logic [31:0] d; rsp_t e;
    dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 32'h0;
    #1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (dm_ready[1] !== 1'b1) begin
        errors++; $display("FAIL w0_ready%0d got=%b exp=1", j, dm_ready[1]);
      end
      exp_q.push_back('{dm: 1'b1, data: pat(1, j)});
      wait_rsp(1, 0, j == 3, got, own, d, lat, wc, wa);
      e = exp_q.pop_front();
      checks++;
      if (!got || own !== e.dm || d !== e.data || lat != 2) begin
        errors++; $display("FAIL w0_resp%0d got=%b d=%h lat=%0d exp=1 d=%h lat=2", j, got, d, lat, e.data);
      end
      dm_addr[1] = 32'((j + 1) * 4);
      tick();
    end
    checks++;
    if (dm_ready[1] !== 1'b0) begin
      errors++; $display("FAIL w0_idle got=%b exp=0", dm_ready[1]);
    end
  endtask

  task automatic test_reset_mid_write();
    int w, lat, wc, wa; bit got, own; logic [31:0] d; rsp_t e;
    int pulses = 0;
    issue(2, 1, 1, 32'hC, 32'hCAFEF00D, w);
    tick();
    dm_req[2] = 1'b0;
    #1;
    checks++;
    if (mem_addr[2] !== 32'hC || mem_we[2] !== 1'b0) begin
      errors++; $display("FAIL rmw_access got=%h/%b exp=0000000c/0", mem_addr[2], mem_we[2]);
    end
    #1;
    rst[2] = 1'b1;
    #1;
    checks++;
    if (mem_addr[2] !== '0 || mem_wdata[2] !== '0 || mem_we[2] !== 1'b0 ||
        {dm_ready[2], dm_rvalid[2], if_ready[2], if_rvalid[2]} !== 4'b0 || dm_rdata[2] !== '0) begin
      errors++; $display("FAIL rmw_async got=a%h wd=%h we=%b exp=all0", mem_addr[2], mem_wdata[2], mem_we[2]);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_we[2]) pulses++;
    end
    rst[2] = 1'b0;
    tick();
    checks++;
    if (pulses != 0 || mem[2][3] !== pat(2, 3)) begin
      errors++; $display("FAIL rmw_nocommit got=we%0d mem=%h exp=we0 mem=%h", pulses, mem[2][3], pat(2, 3));
    end
    issue(2, 1, 0, 32'hC, '0, w);
    exp_q.push_back('{dm: 1'b1, data: pat(2, 3)});
    wait_rsp(2, 0, 1, got, own, d, lat, wc, wa);
    e = exp_q.pop_front();
    checks++;
    if (w != 0 || !got || d !== e.data || lat != 4) begin
      errors++; $display("FAIL rmw_after got=w%0d %b d=%h lat=%0d exp=w0 1 d=%h lat=4", w, got, d, lat, e.data);
    end
    tick();
  endtask

  task automatic test_idle();
    int lat, wc, wa; bit got, own; logic [31:0] d; rsp_t e;
    int bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if ({if_ready[1], if_rvalid[1], dm_ready[1], dm_rvalid[1], mem_we[1]} !== 5'b0 ||
          (mem_addr[1] | mem_wdata[1] | if_rdata[1] | dm_rdata[1]) !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_quiet got=%0d_bad_cycles exp=0", bad);
    end
    rst[1] = 1'b1;
    tick();
    tick();
    rst[1] = 1'b0;
    dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 32'h10;
    #1;
    checks++;
    if (dm_ready[1] !== 1'b1) begin
      errors++; $display("FAIL idle_release_ready got=%b exp=1", dm_ready[1]);
    end
    exp_q.push_back('{dm: 1'b1, data: pat(1, 4)});
    wait_rsp(1, 0, 1, got, own, d, lat, wc, wa);
    e = exp_q.pop_front();
    checks++;
    if (!got || own !== e.dm || d !== e.data || lat != 2) begin
      errors++; $display("FAIL idle_release_resp got=%b d=%h lat=%0d exp=1 d=%h lat=2", got, d, lat, e.data);
    end
    tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      if_addr[k] = '0; dm_addr[k] = '0; dm_wdata[k] = '0;
    end
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_wait0();
    test_reset_mid_write();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
